// File: rtl/nbit_seq_shift_right.sv
// Iterative right shifter (SRL/SRA): one bit position per clock, valid/ready on both sides.
// Latency: result valid shamt+1 cycles after accept (shamt=0 -> next cycle); min period shamt+2.
// Backpressure: result held in DONE until out_ready; in_ready low from accept until DONE drains.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (x, shamt, arith sampled at accept only)
//   x [N-1:0]             operand
//   shamt [SHAMT_W-1:0]   shift amount, 0..N-1
//   arith                 1 = sign-fill, 0 = zero-fill
//   out_valid / out_ready result handshake
//   y [N-1:0]             result (shift register, held while out_valid && !out_ready)
//   busy                  high while an operation is in SHIFT or DONE
//
// Build option: SHR_ARITH_EN -- when defined, arith selects sign-fill; when undefined,
// arith is ignored, fill is constant zero and no fill register exists.

module nbit_seq_shift_right #(
  parameter int N       = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       x,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       y,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_nxt;
  logic [N-1:0]       y_q, y_nxt;
  logic [SHAMT_W-1:0] count_q, count_nxt;
  logic               fill;
  logic               accept;

  // Decoded from state only; rst gating keeps in_ready low while reset is held.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign y         = y_q;

  assign accept = in_valid && in_ready;

`ifdef SHR_ARITH_EN
  logic fill_q, fill_nxt;

  assign fill = fill_q;

  always_comb begin
    fill_nxt = fill_q;
    if (accept) begin
      fill_nxt = arith & x[N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q <= 1'b0;
    end else begin
      fill_q <= fill_nxt;
    end
  end
`else
  // Logical-only build: arith is kept on the port for drop-in compatibility.
  logic unused_arith;
  assign unused_arith = arith;
  assign fill         = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    y_nxt     = y_q;
    count_nxt = count_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          y_nxt     = x;
          count_nxt = shamt;
          state_nxt = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end

      S_SHIFT: begin
        y_nxt     = {fill, y_q[N-1:1]};
        count_nxt = count_q - SHAMT_W'(1);
        // Last shift happens on the edge where count reads 1.
        if (count_q == SHAMT_W'(1)) begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        // No accept here: in_ready is low in DONE, so the next operand waits a cycle.
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_nxt;
      y_q     <= y_nxt;
      count_q <= count_nxt;
    end
  end

endmodule

// File: tb/tb_nbit_seq_shift_right.sv
// Testbench for nbit_seq_shift_right (N=32): directed cases plus randomized operands,
// compared against a word-level shift model; also covers backpressure and mid-op reset.
// Honours SHR_ARITH_EN in the model the same way the build does.

module tb_nbit_seq_shift_right;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [4:0]  shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        busy;

  int total = 0;
  int bad   = 0;

  nbit_seq_shift_right #(.N(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .shamt     (shamt),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Word-level reference: signed >>> for sign-fill, >> for zero-fill.
  function automatic logic [31:0] ref_shr(input logic [31:0] xv, input logic [4:0] sv,
                                          input logic av);
    logic signed [31:0] sx;
    logic               sign_fill;
    sx = xv;
`ifdef SHR_ARITH_EN
    sign_fill = av;
`else
    sign_fill = 1'b0 & av;
`endif
    if (sign_fill) return sx >>> sv;
    return xv >> sv;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, wait for result, hold it 'hold' cycles, drain.
  task automatic run_op(input string name, input logic [31:0] xv, input logic [4:0] sv,
                        input logic av, input int hold, input bit scramble);
    int          guard;
    int          lat;
    logic [31:0] exp_y;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk({name, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    x         = xv;
    shamt     = sv;
    arith     = av;
    out_ready = 1'b0;
    exp_y     = ref_shr(xv, sv, av);
    tick();  // accept edge
    lat = 1;
    if (!scramble) in_valid = 1'b0;
    chk({name, "_busy"}, busy, 1);
    while (!out_valid && lat < 40) begin
      if (scramble) begin
        x         = $urandom;
        shamt     = 5'($urandom);
        arith     = 1'($urandom);
        out_ready = 1'($urandom);
      end
      tick();
      lat++;
    end
    out_ready = 1'b0;
    chk({name, "_latency"}, lat, sv + 1);
    chk({name, "_y"}, y, exp_y);
    for (int i = 0; i < hold; i++) begin
      if (scramble) x = $urandom;
      tick();
      chk({name, "_hold_y"}, y, exp_y);
      chk({name, "_hold_in_ready"}, in_ready, 0);
      chk({name, "_hold_out_valid"}, out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_drain_out_valid"}, out_valid, 0);
    chk({name, "_drain_in_ready"}, in_ready, 1);
    chk({name, "_drain_busy"}, busy, 0);
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x         = '0;
    shamt     = '0;
    arith     = 1'b0;
    out_ready = 1'b0;

    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 32'h0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Directed cases from the test plan, checked against literal values too.
    run_op("lsr4", 32'hF000_000F, 5'd4, 1'b0, 0, 1'b0);
    chk("lsr4_const", ref_shr(32'hF000_000F, 5'd4, 1'b0), 32'h0F00_0000);
`ifdef SHR_ARITH_EN
    run_op("asr4", 32'h8000_0010, 5'd4, 1'b1, 0, 1'b0);
    chk("asr4_y_const", y, 32'hF800_0001);
    run_op("asr31", 32'h8000_0000, 5'd31, 1'b1, 0, 1'b0);
    chk("asr31_y_const", y, 32'hFFFF_FFFF);
`else
    run_op("asr4", 32'h8000_0010, 5'd4, 1'b1, 0, 1'b0);
    chk("asr4_y_const", y, 32'h0800_0001);
    run_op("asr31", 32'h8000_0000, 5'd31, 1'b1, 0, 1'b0);
    chk("asr31_y_const", y, 32'h0000_0001);
`endif
    run_op("sh0", 32'h1234_5678, 5'd0, 1'b0, 0, 1'b0);
    chk("sh0_y_const", y, 32'h1234_5678);
    run_op("bp10", 32'hDEAD_BEEF, 5'd7, 1'b1, 10, 1'b0);
    run_op("scram", 32'h9ABC_DEF0, 5'd13, 1'b1, 3, 1'b1);

    // Mid-operation reset: the in-flight result must never appear.
    in_valid = 1'b1;
    x        = 32'hCAFE_F00D;
    shamt    = 5'd20;
    arith    = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_y", y, 32'h0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    chk("mid_rst_release_in_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_result", seen, 0);
    run_op("after_rst", 32'h8765_4321, 5'd9, 1'b1, 1, 1'b0);

    // Randomized operations, corner shift amounts biased in.
    for (int i = 0; i < 30; i++) begin
      logic [4:0] sv;
      case (i % 6)
        0:       sv = 5'd0;
        1:       sv = 5'd31;
        default: sv = 5'($urandom);
      endcase
      run_op("rand", $urandom, sv, 1'($urandom), int'($urandom_range(0, 3)),
             bit'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
